rx_stream_arbiter: RTL and testbench
====================================

Name: rx_stream_arbiter

Overview:
Merges the packet outputs of NUM_CH serial-receiver channels into one downstream packet stream in the aclk domain. Each channel presents complete packet_length-bit words with a valid/ready handshake. The block grants channels round-robin, allowing up to MAX_BURST consecutive packets per grant, and tags each output word with its source channel. It also keeps per-channel accepted-packet counters and a per-channel enable mask that firmware uses to configure the receiver bank.

Parameters:
NUM_CH, 4, number of receiver channels (2..16)
packet_length, 32, data width of one packet word
MAX_BURST, 4, max consecutive packets granted to one channel while others wait (>=1)
CNT_W, 16, width of each per-channel packet counter

Ports:
aclk  in  1  system clock; all logic on rising edge
aresetn  in  1  synchronous active-low reset, sampled on aclk rising edge
in_data  in  NUM_CH*packet_length  channel i word at bits [i*packet_length +: packet_length]
in_valid  in  NUM_CH  per-channel word valid
in_ready  out  NUM_CH  per-channel accept; at most one bit high per cycle
ch_enable  in  NUM_CH  channel enable mask; a disabled channel is never granted
out_data  out  packet_length  registered output word
out_chan  out  clog2(NUM_CH)  source channel of out_data
out_valid  out  1  output word valid
out_ready  in  1  downstream accept
cnt_clr  in  1  one-cycle pulse; clears all packet counters
cnt_sel  in  clog2(NUM_CH)  counter select
cnt_value  out  CNT_W  registered counter value for channel cnt_sel

Behaviour:
- Reset (aresetn=0 at an edge): out_valid=0, out_data=0, out_chan=0, cnt_value=0, all counters=0, rr pointer=0, burst count=0, state=IDLE. in_ready=0 while aresetn=0. Reset mid-operation drops any held output word without delivering it.
- slot_free = ~out_valid | out_ready. in_ready[g]=1 only for the granted channel g, and only when slot_free. in_ready may depend on in_valid. out_valid never depends on out_ready.
- Transfer on in_valid[g] & in_ready[g]: out_data<=in_data[g] and out_chan<=g at the next edge, with out_valid<=1. Latency is 1 cycle. Throughput is 1 word/cycle, including a load in the same cycle as out_ready consumes the held word.
- When out_valid & out_ready and there is no new transfer, out_valid<=0. When out_valid & ~out_ready, out_data and out_chan hold stable.
- Eligible set E = in_valid & ch_enable.
- State IDLE: if E is nonzero and slot_free, grant the first set bit of E searching from ptr upward with wrap. Go to OWN(owner=g), burst=1 on transfer. If E is zero, stay in IDLE.
- State OWN:
  - Keep the owner if E[owner]=1 and burst<MAX_BURST, or if E has no other bit set. On each transfer, burst+=1, saturating at MAX_BURST.
  - Otherwise re-arbitrate in the same cycle from owner+1 with wrap. Set ptr to the new owner+1 and burst=1 on transfer. If E is zero, go to IDLE with ptr=owner+1.
- MAX_BURST=1 degenerates to strict round-robin per packet.
- Clearing ch_enable[owner] mid-burst: in_ready[owner] drops in that cycle, re-arbitration happens the same cycle, and an already-registered word is still delivered.
- No grant is made while ~slot_free. Grants hold and no word is lost under backpressure.
- Counters: cnt[i] increments on each accepted transfer from channel i and wraps 2^CNT_W-1 -> 0. If cnt_clr coincides with an increment, clear wins (result 0).
- cnt_value <= cnt[cnt_sel] each cycle (1-cycle read latency). cnt_sel >= NUM_CH reads 0.

Decomposition:
- Package rx_pkg holds:
  - arb_state_t {IDLE, OWN}
  - localparam CH_W = clog2(NUM_CH), with minimum 1
  - a function for round-robin first-set-bit search
- Sub-module rx_rr_pick (combinational): inputs req[NUM_CH] and start pointer; outputs one-hot grant and index. It is instantiated once, fed by the IDLE/OWN rotation start.

Test Plan:
- Single channel: ch_enable=4'b0001, ch0 sends 0xDEADBEEF, out_ready=1. Expect out_valid one cycle after the handshake, out_data=0xDEADBEEF, out_chan=0, cnt[0]=1.
- Fairness: all 4 channels continuously valid, MAX_BURST=4, out_ready=1. Expect out_chan sequence 0,0,0,0,1,1,1,1,2,... with no gaps, and in_ready one-hot every cycle.
- Backpressure: out_ready=0 for 10 cycles with ch1 valid. Expect out_valid held, out_data stable, in_ready=0. Release out_ready and expect the next ch1 word accepted in the same cycle.
- Disable mid-burst: ch2 owner at burst=2, clear ch_enable[2]. Expect in_ready[2]=0 that cycle, grant moves to ch3, and ch2's registered word is still output.
- Counters: 65537 ch0 packets give cnt[0]=1 (wrap). cnt_clr coinciding with a ch0 transfer gives cnt_value=0 two cycles later with cnt_sel=0.
- Reset mid-transfer: out_valid=1 with out_ready=0, aresetn=0 for one edge. Expect out_valid=0, all counters 0, next grant starts from ch0.

Source files
------------

// File: rtl/rx_pkg.sv
// Shared types and helpers for the receiver stream arbiter: FSM state encoding,
// channel-index width, and the round-robin first-set-bit search.
package rx_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    // Upper bound on channel count; sizes the search function's request vector.
    localparam int MAX_CH   = 16;
    localparam int MAX_CH_W = $clog2(MAX_CH);

    // Channel index width, never narrower than one bit.
    function automatic int ch_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int CH_W = ch_width(4);

    // Returns the first set bit of req[n-1:0], scanning from start upward with
    // wrap, or -1 when no bit is set. The scan walks down so the lowest offset wins.
    function automatic int rr_first(input logic [MAX_CH-1:0] req, input int n, input int start);
        int result;
        int idx;
        int base;
        result = -1;
        base   = (start >= n || start < 0) ? 0 : start;
        for (int k = MAX_CH - 1; k >= 0; k--) begin
            if (k < n) begin
                idx = base + k;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (req[idx[MAX_CH_W-1:0]]) begin
                    result = idx;
                end
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/rx_rr_pick.sv
// Combinational rotating priority pick: one-hot grant plus index of the first
// requesting channel at or after the start pointer.
module rx_rr_pick
    import rx_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = 2
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  start,
    output logic [NUM_CH-1:0] grant,
    output logic [IDX_W-1:0]  grant_idx
);

    logic [MAX_CH-1:0] req_ext;
    logic              found;
    int                pick;

    always_comb begin
        req_ext             = '0;
        req_ext[NUM_CH-1:0] = req;
        pick                = rr_first(req_ext, NUM_CH, int'(start));
        found               = (pick >= 0);
        grant_idx           = found ? pick[IDX_W-1:0] : '0;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_grant
            assign grant[gi] = found && (grant_idx == IDX_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/rx_stream_arbiter.sv
// Merges NUM_CH receiver packet streams into one tagged output stream using
// round-robin grants with bounded bursts, plus per-channel packet counters.
module rx_stream_arbiter
    import rx_pkg::*;
#(
    parameter  int NUM_CH        = 4,
    parameter  int packet_length = 32,
    parameter  int MAX_BURST     = 4,
    parameter  int CNT_W         = 16,
    localparam int SEL_W         = ch_width(NUM_CH)
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic [NUM_CH*packet_length-1:0] in_data,
    input  logic [NUM_CH-1:0]               in_valid,
    output logic [NUM_CH-1:0]               in_ready,
    input  logic [NUM_CH-1:0]               ch_enable,
    output logic [packet_length-1:0]        out_data,
    output logic [SEL_W-1:0]                out_chan,
    output logic                            out_valid,
    input  logic                            out_ready,
    input  logic                            cnt_clr,
    input  logic [SEL_W-1:0]                cnt_sel,
    output logic [CNT_W-1:0]                cnt_value
);

    localparam int BURST_W = $clog2(MAX_BURST + 1);

    arb_state_t                 state_reg, state_next;
    logic [SEL_W-1:0]           owner_reg, owner_next;
    logic [SEL_W-1:0]           ptr_reg, ptr_next;
    logic [BURST_W-1:0]         burst_reg, burst_next;
    logic                       out_valid_reg, out_valid_next;
    logic [packet_length-1:0]   out_data_reg, out_data_next;
    logic [SEL_W-1:0]           out_chan_reg, out_chan_next;
    logic [CNT_W-1:0]           cnt_value_reg, cnt_value_next;

    logic [NUM_CH-1:0]          elig;
    logic [NUM_CH-1:0]          owner_oh;
    logic [NUM_CH-1:0]          pick_oh;
    logic [NUM_CH-1:0]          grant_oh;
    logic [SEL_W-1:0]           pick_idx;
    logic [SEL_W-1:0]           pick_start;
    logic [SEL_W-1:0]           grant_idx;
    logic                       slot_free;
    logic                       keep_owner;
    logic                       xfer;
    logic [NUM_CH*CNT_W-1:0]    cnt_flat;

    function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] v);
        return (int'(v) >= NUM_CH - 1) ? '0 : v + 1'b1;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_owner_dec
            assign owner_oh[gi] = (owner_reg == SEL_W'(gi));
        end
    endgenerate

    assign elig      = in_valid & ch_enable;
    assign slot_free = ~out_valid_reg | out_ready;

    // The owner keeps the grant until its burst is spent, unless nobody else wants it.
    assign keep_owner = (state_reg == OWN) && |(elig & owner_oh) &&
                        ((burst_reg < BURST_W'(MAX_BURST)) || ((elig & ~owner_oh) == '0));

    // Rotation starts after the current owner; from IDLE it starts at the saved pointer.
    assign pick_start = (state_reg == OWN) ? wrap_inc(owner_reg) : ptr_reg;

    rx_rr_pick #(
        .NUM_CH (NUM_CH),
        .IDX_W  (SEL_W)
    ) u_pick (
        .req       (elig),
        .start     (pick_start),
        .grant     (pick_oh),
        .grant_idx (pick_idx)
    );

    assign grant_oh  = keep_owner ? owner_oh  : pick_oh;
    assign grant_idx = keep_owner ? owner_reg : pick_idx;
    assign in_ready  = (aresetn && slot_free) ? grant_oh : '0;
    assign xfer      = |(in_ready & in_valid);

    always_comb begin
        state_next     = state_reg;
        owner_next     = owner_reg;
        ptr_next       = ptr_reg;
        burst_next     = burst_reg;
        out_valid_next = out_valid_reg;
        out_data_next  = out_data_reg;
        out_chan_next  = out_chan_reg;
        cnt_value_next = '0;

        if (xfer) begin
            state_next     = OWN;
            owner_next     = grant_idx;
            ptr_next       = wrap_inc(grant_idx);
            out_valid_next = 1'b1;
            out_data_next  = in_data[grant_idx*packet_length +: packet_length];
            out_chan_next  = grant_idx;
            if (keep_owner) begin
                burst_next = (burst_reg < BURST_W'(MAX_BURST)) ? burst_reg + 1'b1 : burst_reg;
            end else begin
                burst_next = BURST_W'(1);
            end
        end else begin
            if (out_ready) begin
                out_valid_next = 1'b0;
            end
            if ((state_reg == OWN) && (elig == '0)) begin
                state_next = IDLE;
                ptr_next   = wrap_inc(owner_reg);
                burst_next = '0;
            end
        end

        if (int'(cnt_sel) < NUM_CH) begin
            cnt_value_next = cnt_flat[cnt_sel*CNT_W +: CNT_W];
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_reg     <= IDLE;
            owner_reg     <= '0;
            ptr_reg       <= '0;
            burst_reg     <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_chan_reg  <= '0;
            cnt_value_reg <= '0;
        end else begin
            state_reg     <= state_next;
            owner_reg     <= owner_next;
            ptr_reg       <= ptr_next;
            burst_reg     <= burst_next;
            out_valid_reg <= out_valid_next;
            out_data_reg  <= out_data_next;
            out_chan_reg  <= out_chan_next;
            cnt_value_reg <= cnt_value_next;
        end
    end

    // Per-channel accepted-packet counters; a clear pulse beats a same-cycle increment.
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;
            always_ff @(posedge aclk) begin
                if (!aresetn || cnt_clr) begin
                    cnt_reg <= '0;
                end else if (in_valid[gi] && in_ready[gi]) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
            assign cnt_flat[gi*CNT_W +: CNT_W] = cnt_reg;
        end
    endgenerate

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_chan  = out_chan_reg;
    assign cnt_value = cnt_value_reg;

endmodule

// File: tb/tb_rx_stream_arbiter.sv
// Self-checking bench for rx_stream_arbiter: directed scenarios plus randomized
// traffic compared against a rule-level behavioural model of the arbiter.
module tb_rx_stream_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int MB = 4;
    localparam int CW = 8;

    logic           aclk = 1'b0;
    logic           aresetn;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [N-1:0]   ch_enable;
    logic [W-1:0]   out_data;
    logic [1:0]     out_chan;
    logic           out_valid;
    logic           out_ready;
    logic           cnt_clr;
    logic [1:0]     cnt_sel;
    logic [CW-1:0]  cnt_value;

    always #5 aclk = ~aclk;

    rx_stream_arbiter #(
        .NUM_CH        (N),
        .packet_length (W),
        .MAX_BURST     (MB),
        .CNT_W         (CW)
    ) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ch_enable (ch_enable),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cnt_clr   (cnt_clr),
        .cnt_sel   (cnt_sel),
        .cnt_value (cnt_value)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: owner = -1 means nobody holds the grant.
    logic          m_valid = 1'b0;
    logic [W-1:0]  m_data  = '0;
    logic [1:0]    m_chan  = '0;
    logic [CW-1:0] m_cnt_value = '0;
    int            m_cnt[N];
    int            m_owner = -1;
    int            m_burst = 0;
    int            m_ptr   = 0;
    int            m_grant = -1;
    logic [N-1:0]  exp_ready;
    logic [N-1:0]  obs_ready;

    // Decide who should be granted this cycle from the arbitration rules.
    task automatic model_comb();
        logic [N-1:0] e;
        logic         slot;
        int           start;
        int           idx;
        e       = in_valid & ch_enable;
        slot    = !m_valid || out_ready;
        m_grant = -1;
        if (m_owner >= 0 && e[m_owner] &&
            (m_burst < MB || (e & ~(N'(1) << m_owner)) == '0)) begin
            m_grant = m_owner;
        end else begin
            start = (m_owner >= 0) ? (m_owner + 1) % N : m_ptr;
            for (int k = 0; k < N && m_grant < 0; k++) begin
                idx = (start + k) % N;
                if (e[idx]) m_grant = idx;
            end
        end
        exp_ready = '0;
        if (aresetn && slot && m_grant >= 0) exp_ready[m_grant] = 1'b1;
    endtask

    task automatic model_update();
        logic [N-1:0] e;
        e = in_valid & ch_enable;
        if (!aresetn) begin
            m_valid = 1'b0; m_data = '0; m_chan = '0; m_cnt_value = '0;
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
            m_owner = -1; m_burst = 0; m_ptr = 0;
            return;
        end
        m_cnt_value = CW'(m_cnt[cnt_sel]);
        if (exp_ready != '0) begin
            m_valid = 1'b1;
            m_data  = in_data[m_grant*W +: W];
            m_chan  = m_grant[1:0];
            m_burst = (m_owner == m_grant) ? ((m_burst < MB) ? m_burst + 1 : MB) : 1;
            m_owner = m_grant;
            m_ptr   = (m_grant + 1) % N;
            m_cnt[m_grant] = (m_cnt[m_grant] + 1) % (1 << CW);
        end else begin
            if (out_ready) m_valid = 1'b0;
            if (m_owner >= 0 && e == '0) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end
        end
        if (cnt_clr) for (int i = 0; i < N; i++) m_cnt[i] = 0;
    endtask

    // One clock: sample in_ready mid-cycle, advance model, settle after the edge.
    task automatic step();
        @(negedge aclk);
        model_comb();
        obs_ready = in_ready;
        model_update();
        @(posedge aclk);
        #1;
    endtask

    task automatic rand_data();
        for (int c = 0; c < N; c++) in_data[c*W +: W] = $urandom;
    endtask

    task automatic do_reset();
        aresetn = 1'b0; in_valid = '0; cnt_clr = 1'b0;
        step();
        aresetn = 1'b1;
    endtask

    task automatic test_reset();
        aresetn = 1'b0; in_valid = '1; ch_enable = '1; out_ready = 1'b1;
        cnt_clr = 1'b0; cnt_sel = '0; rand_data();
        step();
        n_checks++; if (obs_ready !== '0) $display("FAIL reset_in_ready got %b want 0000", obs_ready); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
        n_checks++; if (out_data !== '0) $display("FAIL reset_out_data got %h want 0", out_data); else n_pass++;
        n_checks++; if (out_chan !== '0) $display("FAIL reset_out_chan got %0d want 0", out_chan); else n_pass++;
        n_checks++; if (cnt_value !== '0) $display("FAIL reset_cnt_value got %0d want 0", cnt_value); else n_pass++;
        aresetn = 1'b1; in_valid = '0;
    endtask

    task automatic test_single_channel();
        ch_enable = 4'b0001; in_valid = 4'b0001; out_ready = 1'b1;
        rand_data(); in_data[31:0] = 32'hDEADBEEF;
        step();
        n_checks++; if (obs_ready !== 4'b0001) $display("FAIL single_in_ready got %b want 0001", obs_ready); else n_pass++;
        n_checks++; if (out_valid !== 1'b1) $display("FAIL single_out_valid got %b want 1", out_valid); else n_pass++;
        n_checks++; if (out_data !== 32'hDEADBEEF) $display("FAIL single_out_data got %h want deadbeef", out_data); else n_pass++;
        n_checks++; if (out_chan !== 2'd0) $display("FAIL single_out_chan got %0d want 0", out_chan); else n_pass++;
        in_valid = '0; cnt_sel = 2'd0;
        step();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL single_drain got %b want 0", out_valid); else n_pass++;
        n_checks++; if (cnt_value !== CW'(1)) $display("FAIL single_cnt got %0d want 1", cnt_value); else n_pass++;
    endtask

    task automatic test_fairness();
        do_reset();
        ch_enable = '1; in_valid = '1; out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rand_data();
            step();
            n_checks++;
            if (obs_ready !== (N'(1) << ((i / 4) % 4)) || !$onehot(obs_ready))
                $display("FAIL fair_in_ready[%0d] got %b want %b", i, obs_ready, N'(1) << ((i / 4) % 4));
            else n_pass++;
            n_checks++;
            if (out_valid !== 1'b1 || out_chan !== 2'((i / 4) % 4))
                $display("FAIL fair_chan[%0d] got v=%b ch=%0d want v=1 ch=%0d", i, out_valid, out_chan, (i / 4) % 4);
            else n_pass++;
            n_checks++; if (out_data !== m_data) $display("FAIL fair_data[%0d] got %h want %h", i, out_data, m_data); else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] held;
        do_reset();
        ch_enable = '1; in_valid = 4'b0010; out_ready = 1'b1; rand_data();
        held = in_data[W +: W];
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rand_data();
            step();
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== held || obs_ready !== '0)
                $display("FAIL bp_hold[%0d] got v=%b d=%h rdy=%b want v=1 d=%h rdy=0000",
                         i, out_valid, out_data, obs_ready, held);
            else n_pass++;
        end
        out_ready = 1'b1; rand_data();
        held = in_data[W +: W];
        step();
        n_checks++; if (obs_ready !== 4'b0010) $display("FAIL bp_release_ready got %b want 0010", obs_ready); else n_pass++;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== held || out_chan !== 2'd1)
            $display("FAIL bp_release_word got v=%b d=%h ch=%0d want v=1 d=%h ch=1", out_valid, out_data, out_chan, held);
        else n_pass++;
    endtask

    task automatic test_disable_mid_burst();
        do_reset();
        ch_enable = '1; in_valid = 4'b0100; out_ready = 1'b1;
        rand_data(); step();
        rand_data(); step();
        n_checks++;
        if (out_valid !== 1'b1 || out_chan !== 2'd2)
            $display("FAIL dis_ch2_word got v=%b ch=%0d want v=1 ch=2", out_valid, out_chan);
        else n_pass++;
        in_valid = 4'b1100; ch_enable = 4'b1011; rand_data();
        step();
        n_checks++; if (obs_ready !== 4'b1000) $display("FAIL dis_in_ready got %b want 1000", obs_ready); else n_pass++;
        n_checks++;
        if (out_chan !== 2'd3 || out_data !== in_data[3*W +: W])
            $display("FAIL dis_regrant got ch=%0d d=%h want ch=3 d=%h", out_chan, out_data, in_data[3*W +: W]);
        else n_pass++;
    endtask

    task automatic test_counters();
        do_reset();
        ch_enable = 4'b0001; in_valid = 4'b0001; out_ready = 1'b1; cnt_sel = 2'd0;
        for (int i = 0; i < (1 << CW) + 1; i++) begin
            rand_data();
            step();
        end
        in_valid = '0;
        step();
        n_checks++;
        if (cnt_value !== CW'(1) || cnt_value !== m_cnt_value)
            $display("FAIL cnt_wrap got %0d want 1", cnt_value);
        else n_pass++;
        in_valid = 4'b0001; cnt_clr = 1'b1;
        step();
        in_valid = '0; cnt_clr = 1'b0;
        step();
        n_checks++; if (cnt_value !== '0) $display("FAIL cnt_clr_wins got %0d want 0", cnt_value); else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        ch_enable = '1; in_valid = 4'b0010; out_ready = 1'b1; rand_data();
        step();
        in_valid = '0; out_ready = 1'b0;
        step();
        n_checks++; if (out_valid !== 1'b1) $display("FAIL rmid_held got %b want 1", out_valid); else n_pass++;
        aresetn = 1'b0; in_valid = 4'b0010;
        step();
        n_checks++;
        if (out_valid !== 1'b0 || obs_ready !== '0)
            $display("FAIL rmid_drop got v=%b rdy=%b want v=0 rdy=0000", out_valid, obs_ready);
        else n_pass++;
        aresetn = 1'b1; in_valid = '0; out_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            cnt_sel = 2'(i);
            step();
            n_checks++; if (cnt_value !== '0) $display("FAIL rmid_cnt[%0d] got %0d want 0", i, cnt_value); else n_pass++;
        end
        in_valid = '1; rand_data();
        step();
        n_checks++;
        if (obs_ready !== 4'b0001 || out_chan !== 2'd0)
            $display("FAIL rmid_first_grant got rdy=%b ch=%0d want rdy=0001 ch=0", obs_ready, out_chan);
        else n_pass++;
    endtask

    task automatic test_random();
        do_reset();
        ch_enable = '1;
        for (int i = 0; i < 600; i++) begin
            in_valid  = N'($urandom);
            if ($urandom_range(0, 7) == 0) ch_enable = N'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            cnt_clr   = ($urandom_range(0, 63) == 0);
            cnt_sel   = 2'($urandom);
            aresetn   = ($urandom_range(0, 99) != 0);
            rand_data();
            step();
            n_checks++;
            if (obs_ready !== exp_ready || !$onehot0(obs_ready))
                $display("FAIL rnd_in_ready[%0d] got %b want %b", i, obs_ready, exp_ready);
            else n_pass++;
            n_checks++;
            if (out_valid !== m_valid || out_data !== m_data || out_chan !== m_chan)
                $display("FAIL rnd_out[%0d] got v=%b d=%h ch=%0d want v=%b d=%h ch=%0d",
                         i, out_valid, out_data, out_chan, m_valid, m_data, m_chan);
            else n_pass++;
            n_checks++;
            if (cnt_value !== m_cnt_value)
                $display("FAIL rnd_cnt[%0d] got %0d want %0d", i, cnt_value, m_cnt_value);
            else n_pass++;
        end
        aresetn = 1'b1; cnt_clr = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        in_data = '0; in_valid = '0; ch_enable = '0; out_ready = 1'b0;
        cnt_clr = 1'b0; cnt_sel = '0; aresetn = 1'b0;
        test_reset();
        test_single_channel();
        test_fairness();
        test_backpressure();
        test_disable_mid_burst();
        test_counters();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
